hazard_ctrl: RTL and testbench



---
 rtl/hazard_pkg.sv | 22 ++
 rtl/hazard_ctrl_if.sv | 50 +++++
 rtl/mc_seq_counter.sv | 62 ++++++
 rtl/hazard_ctrl.sv | 90 +++++++++
 tb/tb_hazard_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Purpose: shared types and constants for the pipeline hazard/stall controller.
// Latency: none (declarations only).
// Backpressure: n/a.
package hazard_pkg;

    // Multi-cycle sequencer state encoding
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mc_state_t;

    // Integer R0 is hardwired to zero, so it never carries a real dependency
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Default occupancy of EX for mult/div/FPU ops and matching counter width
    localparam int MC_LATENCY_DEF = 4;
    localparam int CNT_W_DEF      = 4;

    // DInSrc code the Control decoder uses to select memory data (a load)
    localparam logic [1:0] DINSRC_MEM = 2'b01;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Purpose: bundles decode/EX hazard inputs and pipeline register controls.
// Latency: none (wires only); HAZARD_PERF_CNT_EN adds StallCycles/FlushCount.
// Backpressure: n/a; the controls themselves are the pipeline's stall mechanism.
interface hazard_ctrl_if;
    logic [4:0]  IDRs;
    logic [4:0]  IDRt;
    logic        IDUsesRs;
    logic        IDUsesRt;
    logic        IDFPSrc;
    logic        IDMultiCycle;
    logic        EXIsLoad;
    logic        EXRegWE;
    logic [4:0]  EXDest;
    logic        EXFPDest;
    logic        BranchTaken;
    logic        PCHold;
    logic        IFIDHold;
    logic        IDEXHold;
    logic        IDEXBubble;
    logic        IFIDFlush;
    logic        EXMEMBubble;
    logic        MCBusy;
    logic        LoadUseStall;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] StallCycles;
    logic [31:0] FlushCount;
`endif

    // Pipeline side: presents decode/EX status, consumes stall controls
    modport master (
        output IDRs, IDRt, IDUsesRs, IDUsesRt, IDFPSrc, IDMultiCycle,
               EXIsLoad, EXRegWE, EXDest, EXFPDest, BranchTaken,
        input  PCHold, IFIDHold, IDEXHold, IDEXBubble, IFIDFlush,
               EXMEMBubble, MCBusy, LoadUseStall
`ifdef HAZARD_PERF_CNT_EN
        , input StallCycles, FlushCount
`endif
    );

    // Controller side
    modport slave (
        input  IDRs, IDRt, IDUsesRs, IDUsesRt, IDFPSrc, IDMultiCycle,
               EXIsLoad, EXRegWE, EXDest, EXFPDest, BranchTaken,
        output PCHold, IFIDHold, IDEXHold, IDEXBubble, IFIDFlush,
               EXMEMBubble, MCBusy, LoadUseStall
`ifdef HAZARD_PERF_CNT_EN
        , output StallCycles, FlushCount
`endif
    );
endinterface

// File: rtl/mc_seq_counter.sv
// Purpose: tracks a multi-cycle EX op with a down-counter, busy for MC_LATENCY-1 cycles.
// Latency: busy rises the cycle after start is seen in IDLE; falls after the count reaches 1.
// Backpressure: start is ignored while busy; the caller keeps the next op held in ID.
module mc_seq_counter
    import hazard_pkg::*;
#(
    parameter int MC_LATENCY = MC_LATENCY_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy
);

    mc_state_t          state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Load on entry, count down while busy, release when the count hits 1
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                // A single-cycle latency op never needs to hold the pipe
                if (start && (MC_LATENCY > 1)) begin
                    state_nxt = ST_BUSY;
                    cnt_nxt   = CNT_W'(MC_LATENCY - 1);
                end
            end
            ST_BUSY: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Busy indication straight from state
    always_comb begin
        busy = (state == ST_BUSY);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Purpose: load-use / branch-flush / multi-cycle hazard controller (HAZARD_PERF_CNT_EN adds perf counters).
// Latency: controls are combinational from current inputs plus the registered sequencer state.
// Backpressure: asserts PC/IF/ID holds on load-use and for MC_LATENCY-1 cycles per multi-cycle op.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MC_LATENCY = MC_LATENCY_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_ctrl_if.slave  bus
);

    logic ex_is_r0;
    logic hazard;
    logic mc_start;
    logic mc_busy;

    // Load-use compare: same register file, same index, and the operand is really read
    always_comb begin
        ex_is_r0 = !bus.EXFPDest && (bus.EXDest == REG_ZERO);
        hazard   = bus.EXIsLoad && bus.EXRegWE && !ex_is_r0
                && (bus.EXFPDest == bus.IDFPSrc)
                && ((bus.IDUsesRs && (bus.IDRs == bus.EXDest))
                 || (bus.IDUsesRt && (bus.IDRt == bus.EXDest)));
        // A flush or a load-use stall means the ID instruction does not issue
        mc_start = bus.IDMultiCycle && !bus.BranchTaken && !hazard;
    end

    mc_seq_counter #(
        .MC_LATENCY (MC_LATENCY),
        .CNT_W      (CNT_W)
    ) u_mc_seq (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mc_start),
        .busy  (mc_busy)
    );

    // Priority mux: busy beats everything, then branch flush, then load-use stall
    always_comb begin
        bus.PCHold       = 1'b0;
        bus.IFIDHold     = 1'b0;
        bus.IDEXHold     = 1'b0;
        bus.IDEXBubble   = 1'b0;
        bus.IFIDFlush    = 1'b0;
        bus.EXMEMBubble  = 1'b0;
        bus.MCBusy       = 1'b0;
        bus.LoadUseStall = 1'b0;
        // Outputs are forced low during reset even though inputs may be live
        if (rst_n) begin
            if (mc_busy) begin
                bus.PCHold      = 1'b1;
                bus.IFIDHold    = 1'b1;
                bus.IDEXHold    = 1'b1;
                bus.EXMEMBubble = 1'b1;
                bus.MCBusy      = 1'b1;
            end else if (bus.BranchTaken) begin
                bus.IFIDFlush   = 1'b1;
                bus.IDEXBubble  = 1'b1;
            end else if (hazard) begin
                bus.LoadUseStall = 1'b1;
                bus.PCHold       = 1'b1;
                bus.IFIDHold     = 1'b1;
                bus.IDEXBubble   = 1'b1;
            end
        end
    end

    // A branch cannot resolve while the multi-cycle op owns EX
    a_no_branch_in_busy: assert property (@(posedge clk) disable iff (!rst_n)
        !(mc_busy && bus.BranchTaken));

`ifdef HAZARD_PERF_CNT_EN
    // Saturating stall-cycle and flush counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.StallCycles <= '0;
            bus.FlushCount  <= '0;
        end else begin
            if (bus.PCHold && (bus.StallCycles != '1))
                bus.StallCycles <= bus.StallCycles + 32'd1;
            if (bus.IFIDFlush && (bus.FlushCount != '1))
                bus.FlushCount <= bus.FlushCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Purpose: self-checking bench for hazard_ctrl at MC_LATENCY 4 and 3 side by side.
// Latency: inputs driven 1 time unit after posedge, outputs sampled at negedge.
// Backpressure: n/a.
module tb_hazard_ctrl;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       fps;
        logic       mc;
        logic       ld;
        logic       we;
        logic [4:0] dest;
        logic       fpd;
        logic       br;
    } in_t;

    typedef struct {
        in_t        i;
        logic [7:0] exp;
    } tv_t;

    // Output vector order: PCHold IFIDHold IDEXHold IDEXBubble IFIDFlush EXMEMBubble MCBusy LoadUseStall
    localparam logic [7:0] O_NONE  = 8'b0000_0000;
    localparam logic [7:0] O_STALL = 8'b1101_0001;
    localparam logic [7:0] O_FLUSH = 8'b0001_1000;
    localparam logic [7:0] O_BUSY  = 8'b1110_0110;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if hif4 ();
    hazard_ctrl_if hif3 ();

    hazard_ctrl dut4 (.clk(clk), .rst_n(rst_n), .bus(hif4));
    hazard_ctrl #(.MC_LATENCY(3), .CNT_W(4)) dut3 (.clk(clk), .rst_n(rst_n), .bus(hif3));

    logic [7:0] out4, out3;
    assign out4 = {hif4.PCHold, hif4.IFIDHold, hif4.IDEXHold, hif4.IDEXBubble,
                   hif4.IFIDFlush, hif4.EXMEMBubble, hif4.MCBusy, hif4.LoadUseStall};
    assign out3 = {hif3.PCHold, hif3.IFIDHold, hif3.IDEXHold, hif3.IDEXBubble,
                   hif3.IFIDFlush, hif3.EXMEMBubble, hif3.MCBusy, hif3.LoadUseStall};

    int vectors = 0;
    int miscompares = 0;
    int left4 = 0;           // remaining hold cycles expected from the L=4 instance
    int left3 = 0;           // remaining hold cycles expected from the L=3 instance
    logic [7:0] last4, last3;
`ifdef HAZARD_PERF_CNT_EN
    int stall_exp = 0;
    int flush_exp = 0;
`endif

    function automatic in_t mk(int rs, int rt, bit urs, bit urt, bit fps, bit mc,
                               bit ld, bit we, int dest, bit fpd, bit br);
        in_t v;
        v.rs = 5'(rs); v.rt = 5'(rt); v.urs = urs; v.urt = urt; v.fps = fps;
        v.mc = mc; v.ld = ld; v.we = we; v.dest = 5'(dest); v.fpd = fpd; v.br = br;
        return v;
    endfunction

    // Registers named as {file, index}; integer index 0 is the only never-written id
    function automatic bit ref_hazard(in_t v);
        logic [5:0] ex_id, rs_id, rt_id;
        ex_id = {v.fpd, v.dest};
        rs_id = {v.fps, v.rs};
        rt_id = {v.fps, v.rt};
        if (!(v.ld && v.we) || ex_id == 6'd0) return 1'b0;
        return (v.urs && rs_id == ex_id) || (v.urt && rt_id == ex_id);
    endfunction

    function automatic logic [7:0] ref_out(in_t v, int left);
        if (left > 0) return O_BUSY;
        if (v.br) return O_FLUSH;
        if (ref_hazard(v)) return O_STALL;
        return O_NONE;
    endfunction

    function automatic int ref_next(in_t v, int left, int lat);
        if (left > 0) return left - 1;
        if (v.mc && !v.br && !ref_hazard(v) && lat > 1) return lat - 1;
        return 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic apply(input in_t v);
        hif4.IDRs = v.rs; hif4.IDRt = v.rt; hif4.IDUsesRs = v.urs; hif4.IDUsesRt = v.urt;
        hif4.IDFPSrc = v.fps; hif4.IDMultiCycle = v.mc; hif4.EXIsLoad = v.ld;
        hif4.EXRegWE = v.we; hif4.EXDest = v.dest; hif4.EXFPDest = v.fpd; hif4.BranchTaken = v.br;
        hif3.IDRs = v.rs; hif3.IDRt = v.rt; hif3.IDUsesRs = v.urs; hif3.IDUsesRt = v.urt;
        hif3.IDFPSrc = v.fps; hif3.IDMultiCycle = v.mc; hif3.EXIsLoad = v.ld;
        hif3.EXRegWE = v.we; hif3.EXDest = v.dest; hif3.EXFPDest = v.fpd; hif3.BranchTaken = v.br;
    endtask

    // One pipeline cycle: drive, sample at negedge, compare with model (and table if given)
    task automatic step(input in_t v, input bit has_exp, input logic [7:0] exp, input string name);
        logic [7:0] e4;
        apply(v);
        @(negedge clk);
        e4 = ref_out(v, left4);
        check("model_L4", {24'd0, out4}, {24'd0, e4});
        check("model_L3", {24'd0, out3}, {24'd0, ref_out(v, left3)});
        if (has_exp) begin
            check(name, {24'd0, out4}, {24'd0, exp});
            check({name, "_L3"}, {24'd0, out3}, {24'd0, exp});
        end
        last4 = out4;
        last3 = out3;
`ifdef HAZARD_PERF_CNT_EN
        if (e4[7]) stall_exp++;
        if (e4[3]) flush_exp++;
`endif
        left4 = ref_next(v, left4, 4);
        left3 = ref_next(v, left3, 3);
        @(posedge clk);
        #1;
    endtask

    tv_t  tbl[12];
    in_t  zero_v, mc_v, haz_v, rv;
    int   busy4, busy3;
    logic [5:0] pat4, pat3;

    initial begin
        zero_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        mc_v   = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        haz_v  = mk(3, 0, 1, 0, 0, 0, 1, 1, 3, 0, 0);

        tbl[0]  = '{mk(3, 0, 1, 0, 0, 0, 1, 1, 3, 0, 0),   O_STALL};  // int load-use via Rs
        tbl[1]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),   O_NONE};   // stall lasts one cycle
        tbl[2]  = '{mk(0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0),   O_NONE};   // R0 never matches
        tbl[3]  = '{mk(5, 0, 0, 1, 1, 0, 1, 1, 0, 1, 0),   O_STALL};  // f0 via Rt matches
        tbl[4]  = '{mk(7, 0, 1, 0, 0, 0, 1, 1, 7, 1, 0),   O_NONE};   // different register file
        tbl[5]  = '{mk(7, 0, 1, 0, 0, 0, 1, 0, 7, 0, 0),   O_NONE};   // no register write
        tbl[6]  = '{mk(7, 0, 1, 0, 0, 0, 0, 1, 7, 0, 0),   O_NONE};   // not a load
        tbl[7]  = '{mk(7, 9, 0, 1, 0, 0, 1, 1, 7, 0, 0),   O_NONE};   // Rs matches but unused
        tbl[8]  = '{mk(4, 0, 1, 0, 0, 1, 1, 1, 4, 0, 1),   O_FLUSH};  // branch beats stall and mc
        tbl[9]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1),   O_FLUSH};  // plain branch
        tbl[10] = '{mk(0, 12, 0, 1, 0, 1, 1, 1, 12, 0, 0), O_STALL};  // stall suppresses mc entry
        tbl[11] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),   O_NONE};   // confirms no BUSY entry

        // Reset: outputs stay low even with a live hazard on the inputs
        apply(haz_v);
        #2;
        check("reset_L4", {24'd0, out4}, 32'd0);
        check("reset_L3", {24'd0, out3}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) step(tbl[i].i, 1'b1, tbl[i].exp, $sformatf("table%0d", i));

        // Single multi-cycle op: L=4 holds 3 cycles, L=3 holds 2
        busy4 = 0;
        busy3 = 0;
        step(mc_v, 1'b0, O_NONE, "");
        for (int i = 0; i < 5; i++) begin
            step(zero_v, 1'b0, O_NONE, "");
            busy4 += int'(last4[1]);
            busy3 += int'(last3[1]);
        end
        check("mc_hold_cycles_L4", busy4, 32'd3);
        check("mc_hold_cycles_L3", busy3, 32'd2);

        // Back-to-back ops: second op waits in ID while the first is busy
        pat4 = '0;
        pat3 = '0;
        for (int i = 0; i < 6; i++) begin
            step((i < 4) ? mc_v : zero_v, 1'b0, O_NONE, "");
            pat4 = {pat4[4:0], last4[1]};
            pat3 = {pat3[4:0], last3[1]};
        end
        check("b2b_pattern_L3", {26'd0, pat3}, {26'd0, 6'b011011});
        check("b2b_pattern_L4", {26'd0, pat4}, {26'd0, 6'b011100});
        step(zero_v, 1'b0, O_NONE, "");

        // Asynchronous reset in the second BUSY cycle
        step(mc_v, 1'b0, O_NONE, "");
        step(zero_v, 1'b0, O_NONE, "");
        apply(haz_v);
        #1;
        check("busy_before_rst_L4", {24'd0, out4}, {24'd0, O_BUSY});
        check("busy_before_rst_L3", {24'd0, out3}, {24'd0, O_BUSY});
        rst_n = 1'b0;
        #1;
        check("async_rst_L4", {24'd0, out4}, 32'd0);
        check("async_rst_L3", {24'd0, out3}, 32'd0);
        left4 = 0;
        left3 = 0;
`ifdef HAZARD_PERF_CNT_EN
        check("perf_stall_rst", hif4.StallCycles, 32'd0);
        stall_exp = 0;
        flush_exp = 0;
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(zero_v, 1'b1, O_NONE, "post_rst_idle");
        step(tbl[0].i, 1'b1, O_STALL, "post_rst_stall");

        // Randomized traffic; branches only resolve when neither instance is busy
        for (int n = 0; n < 1500; n++) begin
            rv = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                    $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
                    $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
                    $urandom_range(0, 1), 1'b0);
            if (left4 == 0 && left3 == 0 && $urandom_range(0, 7) == 0) rv.br = 1'b1;
            step(rv, 1'b0, O_NONE, "");
        end

`ifdef HAZARD_PERF_CNT_EN
        check("perf_stall_cycles", hif4.StallCycles, stall_exp);
        check("perf_flush_count", hif4.FlushCount, flush_exp);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
